// File: rtl/pixel_nbhd_bram_addr_gen_if.sv
// Request / beat bundle between the labelling FSM, the neighbourhood
// address generator and the image BRAM read port.
interface pixel_nbhd_bram_addr_gen_if #(
  parameter int ROW_W  = 9,
  parameter int COL_W  = 9,
  parameter int ADDR_W = 13,
  parameter int BIT_W  = 5
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ROW_W-1:0]  i_row;
  logic [COL_W-1:0]  i_col;
  logic              i_abort;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] o_addr;
  logic [BIT_W-1:0]  o_bit;
  logic [3:0]        o_nidx;
  logic              o_last;
  logic              o_err;

  modport master (
    output i_req_valid, i_row, i_col, i_abort, i_ready,
    input  o_req_ready, o_valid, o_addr, o_bit, o_nidx, o_last, o_err
  );

  modport slave (
    input  i_req_valid, i_row, i_col, i_abort, i_ready,
    output o_req_ready, o_valid, o_addr, o_bit, o_nidx, o_last, o_err
  );
endinterface

// File: rtl/pixel_nbhd_bram_addr_gen.sv
// Emits BRAM word address / bit offset for each in-image neighbour of an
// accepted centre pixel, one valid/ready beat at a time, in raster order.
module pixel_nbhd_bram_addr_gen #(
  parameter int IMG_ROWS      = 512,
  parameter int IMG_COLS      = 512,
  parameter int ROW_W         = 9,
  parameter int COL_W         = 9,
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 16,
  parameter int ADDR_W        = 13,
  parameter int CONN          = 8
) (
  input logic                      i_clk,
  input logic                      i_rstn,
  pixel_nbhd_bram_addr_gen_if.slave bus
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam int WPR_W = $clog2(WORDS_PER_ROW);
  // Two extra bits: one for the sign, one so r == IMG_ROWS stays positive.
  localparam int RW = ROW_W + 2;
  localparam int CW = COL_W + 2;

  localparam logic [8:0]              CONN_MASK = (CONN == 4) ? 9'b0_1011_1010 : 9'b1_1111_1111;
  localparam logic signed [RW-1:0]    ONE_R     = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0]    ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [RW-1:0]    ZERO_R    = {RW{1'b0}};
  localparam logic signed [CW-1:0]    ZERO_C    = {CW{1'b0}};
  localparam logic signed [RW-1:0]    ROWS_S    = RW'(IMG_ROWS);
  localparam logic signed [CW-1:0]    COLS_S    = CW'(IMG_COLS);
  localparam logic [ROW_W:0]          ROWS_U    = (ROW_W + 1)'(IMG_ROWS);
  localparam logic [COL_W:0]          COLS_U    = (COL_W + 1)'(IMG_COLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  function automatic logic signed [RW-1:0] nbr_row(input logic [ROW_W-1:0] row, input logic [3:0] idx);
    logic signed [RW-1:0] base;
    base = $signed({2'b00, row});
    case (idx)
      4'd0, 4'd1, 4'd2: nbr_row = base - ONE_R;
      4'd3, 4'd4, 4'd5: nbr_row = base;
      default:          nbr_row = base + ONE_R;
    endcase
  endfunction

  function automatic logic signed [CW-1:0] nbr_col(input logic [COL_W-1:0] col, input logic [3:0] idx);
    logic signed [CW-1:0] base;
    base = $signed({2'b00, col});
    case (idx)
      4'd0, 4'd3, 4'd6: nbr_col = base - ONE_C;
      4'd1, 4'd4, 4'd7: nbr_col = base;
      default:          nbr_col = base + ONE_C;
    endcase
  endfunction

  function automatic logic [8:0] legal_mask(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    logic [8:0]           m;
    logic signed [RW-1:0] r;
    logic signed [CW-1:0] c;
    m = 9'd0;
    for (int i = 0; i < 9; i++) begin
      r    = nbr_row(row, 4'(i));
      c    = nbr_col(col, 4'(i));
      m[i] = CONN_MASK[i] && (r >= ZERO_R) && (r < ROWS_S) && (c >= ZERO_C) && (c < COLS_S);
    end
    return m;
  endfunction

  function automatic logic [3:0] first_idx(input logic [8:0] mask);
    logic [3:0] res;
    res = 4'd4;
    for (int i = 8; i >= 0; i--) begin
      if (mask[i]) res = 4'(i);
    end
    return res;
  endfunction

  function automatic logic [3:0] next_idx(input logic [8:0] mask, input logic [3:0] cur);
    logic [3:0] res;
    res = cur;
    for (int i = 8; i >= 0; i--) begin
      if (mask[i] && (4'(i) > cur)) res = 4'(i);
    end
    return res;
  endfunction

  function automatic logic is_last(input logic [8:0] mask, input logic [3:0] cur);
    logic res;
    res = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (mask[i] && (4'(i) > cur)) res = 1'b0;
    end
    return res;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                                                  input logic [3:0] idx);
    logic signed [RW-1:0] r;
    logic signed [CW-1:0] c;
    r = nbr_row(row, idx);
    c = nbr_col(col, idx);
    return (ADDR_W'(r[ROW_W-1:0]) << WPR_W) | ADDR_W'(c[COL_W-1:0] >> BIT_W);
  endfunction

  function automatic logic [BIT_W-1:0] beat_bit(input logic [COL_W-1:0] col, input logic [3:0] idx);
    logic signed [CW-1:0] c;
    c = nbr_col(col, idx);
    return c[BIT_W-1:0];
  endfunction

  state_t             state_r, state_s;
  logic [ROW_W-1:0]   row_r, row_s;
  logic [COL_W-1:0]   col_r, col_s;
  logic [8:0]         mask_r, mask_s, in_mask_s;
  logic [3:0]         nidx_r, nidx_s, first_s, adv_s;
  logic               valid_r, valid_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [BIT_W-1:0]   bit_r, bit_s;
  logic               last_r, last_s;
  logic               err_r, err_s;
  logic               out_of_range_s;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next registered outputs; the beat is held unless it is consumed.
  always_comb begin
    state_s        = state_r;
    row_s          = row_r;
    col_s          = col_r;
    mask_s         = mask_r;
    nidx_s         = nidx_r;
    valid_s        = valid_r;
    addr_s         = addr_r;
    bit_s          = bit_r;
    last_s         = last_r;
    err_s          = 1'b0;
    in_mask_s      = legal_mask(bus.i_row, bus.i_col);
    first_s        = first_idx(in_mask_s);
    adv_s          = next_idx(mask_r, nidx_r);
    out_of_range_s = ({1'b0, bus.i_row} >= ROWS_U) || ({1'b0, bus.i_col} >= COLS_U);
    case (state_r)
      S_IDLE: begin
        valid_s = 1'b0;
        last_s  = 1'b0;
        if (bus.i_req_valid) begin
          if (out_of_range_s) begin
            state_s = S_ERR;
            err_s   = 1'b1;
          end else begin
            state_s = S_EMIT;
            row_s   = bus.i_row;
            col_s   = bus.i_col;
            mask_s  = in_mask_s;
            nidx_s  = first_s;
            valid_s = 1'b1;
            addr_s  = beat_addr(bus.i_row, bus.i_col, first_s);
            bit_s   = beat_bit(bus.i_col, first_s);
            last_s  = is_last(in_mask_s, first_s);
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ERR: begin
        state_s = S_IDLE;
      end
      S_EMIT: begin
        if (bus.i_abort) begin
          state_s = S_IDLE;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end else if (bus.i_ready) begin
          if (last_r) begin
            state_s = S_IDLE;
            valid_s = 1'b0;
            last_s  = 1'b0;
          end else begin
            nidx_s = adv_s;
            addr_s = beat_addr(row_r, col_r, adv_s);
            bit_s  = beat_bit(col_r, adv_s);
            last_s = is_last(mask_r, adv_s);
          end
        end else begin
          state_s = S_EMIT;
        end
      end
      default: begin
        state_s = S_IDLE;
        valid_s = 1'b0;
        last_s  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      row_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
      mask_r  <= 9'd0;
      nidx_r  <= 4'd0;
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      last_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      row_r   <= row_s;
      col_r   <= col_s;
      mask_r  <= mask_s;
      nidx_r  <= nidx_s;
      valid_r <= valid_s;
      addr_r  <= addr_s;
      bit_r   <= bit_s;
      last_r  <= last_s;
      err_r   <= err_s;
    end
  end

  assign bus.o_req_ready = (state_r == S_IDLE);
  assign bus.o_valid     = valid_r;
  assign bus.o_addr      = addr_r;
  assign bus.o_bit       = bit_r;
  assign bus.o_nidx      = nidx_r;
  assign bus.o_last      = last_r;
  assign bus.o_err       = err_r;

endmodule

// File: tb/tb_pixel_nbhd_bram_addr_gen.sv
// Scoreboard bench: a CONN=8 instance and a CONN=4 instance (wider coords so
// out-of-range requests are expressible), selected by sel4.
module tb_pixel_nbhd_bram_addr_gen;

  typedef struct packed {
    logic [3:0]  nidx;
    logic [12:0] addr;
    logic [4:0]  bitw;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       req_valid = 1'b0;
  logic       sel4 = 1'b0;
  logic       ready = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] row = 10'd0;
  logic [9:0] col = 10'd0;

  int    total_cnt = 0;
  int    bad_cnt = 0;
  beat_t sb_q[$];

  always #5 clk = ~clk;

  pixel_nbhd_bram_addr_gen_if #(.ROW_W(9),  .COL_W(9),  .ADDR_W(13), .BIT_W(5)) bus8();
  pixel_nbhd_bram_addr_gen_if #(.ROW_W(10), .COL_W(10), .ADDR_W(13), .BIT_W(5)) bus4();

  assign bus8.i_req_valid = req_valid & ~sel4;
  assign bus8.i_row       = row[8:0];
  assign bus8.i_col       = col[8:0];
  assign bus8.i_ready     = ready;
  assign bus8.i_abort     = abort;
  assign bus4.i_req_valid = req_valid & sel4;
  assign bus4.i_row       = row;
  assign bus4.i_col       = col;
  assign bus4.i_ready     = ready;
  assign bus4.i_abort     = abort;

  pixel_nbhd_bram_addr_gen #(.ROW_W(9), .COL_W(9), .CONN(8)) dut8 (
    .i_clk(clk), .i_rstn(rstn), .bus(bus8)
  );
  pixel_nbhd_bram_addr_gen #(.ROW_W(10), .COL_W(10), .CONN(4)) dut4 (
    .i_clk(clk), .i_rstn(rstn), .bus(bus4)
  );

  logic        obs_valid, obs_last, obs_err, obs_req_ready;
  logic [12:0] obs_addr;
  logic [4:0]  obs_bit;
  logic [3:0]  obs_nidx;
  assign obs_valid     = sel4 ? bus4.o_valid     : bus8.o_valid;
  assign obs_last      = sel4 ? bus4.o_last      : bus8.o_last;
  assign obs_err       = sel4 ? bus4.o_err       : bus8.o_err;
  assign obs_req_ready = sel4 ? bus4.o_req_ready : bus8.o_req_ready;
  assign obs_addr      = sel4 ? bus4.o_addr      : bus8.o_addr;
  assign obs_bit       = sel4 ? bus4.o_bit       : bus8.o_bit;
  assign obs_nidx      = sel4 ? bus4.o_nidx      : bus8.o_nidx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit nb_ok(input int r0, input int c0, input int conn, input int i);
    int r;
    int c;
    if (conn == 4 && !(i == 1 || i == 3 || i == 4 || i == 5 || i == 7)) return 1'b0;
    r = r0 + i / 3 - 1;
    c = c0 + i % 3 - 1;
    return (r >= 0) && (r < 512) && (c >= 0) && (c < 512);
  endfunction

  task automatic push_expected(input int r0, input int c0, input int conn);
    int    hi;
    int    r;
    int    c;
    beat_t b;
    hi = -1;
    for (int i = 0; i < 9; i++) if (nb_ok(r0, c0, conn, i)) hi = i;
    for (int i = 0; i < 9; i++) begin
      if (nb_ok(r0, c0, conn, i)) begin
        r      = r0 + i / 3 - 1;
        c      = c0 + i % 3 - 1;
        b.nidx = 4'(i);
        b.addr = 13'(r * 16 + c / 32);
        b.bitw = 5'(c % 32);
        b.last = (i == hi);
        sb_q.push_back(b);
      end
    end
  endtask

  // Index 15 means "never" for the stall / abort / reset triggers.
  task automatic run_burst(input int r0, input int c0, input int is4, input int stall_idx,
                           input int stall_n, input int abort_idx, input int rst_idx);
    int    budget;
    int    stall_left;
    beat_t e;
    sel4  = (is4 != 0);
    row   = 10'(r0);
    col   = 10'(c0);
    ready = 1'b1;
    abort = 1'b0;
    chk("req_ready_idle", obs_req_ready, 1);
    push_expected(r0, c0, (is4 != 0) ? 4 : 8);
    req_valid = 1'b1;
    step();
    req_valid  = 1'b0;
    stall_left = stall_n;
    budget     = 40;
    while (sb_q.size() > 0 && budget > 0) begin
      budget--;
      chk("beat_valid", obs_valid, 1);
      if (!obs_valid) begin
        sb_q.delete();
        break;
      end
      e = sb_q[0];
      chk("nidx", obs_nidx, e.nidx);
      chk("addr", obs_addr, e.addr);
      chk("bit", obs_bit, e.bitw);
      chk("last", obs_last, e.last);
      chk("busy_ready", obs_req_ready, 0);
      if (int'(obs_nidx) == rst_idx) begin
        rstn = 1'b0;
        #1;
        chk("rst_valid", obs_valid, 0);
        chk("rst_addr", obs_addr, 0);
        chk("rst_bit", obs_bit, 0);
        chk("rst_nidx", obs_nidx, 0);
        chk("rst_last", obs_last, 0);
        chk("rst_req_ready", obs_req_ready, 1);
        sb_q.delete();
        return;
      end
      if (int'(obs_nidx) == stall_idx && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
        step();
        continue;
      end
      if (int'(obs_nidx) == abort_idx) begin
        abort = 1'b1;
        ready = 1'b1;
        step();
        abort = 1'b0;
        sb_q.delete();
        chk("abort_valid", obs_valid, 0);
        chk("abort_ready", obs_req_ready, 1);
        return;
      end
      ready = 1'b1;
      void'(sb_q.pop_front());
      step();
    end
    chk("burst_drained", sb_q.size(), 0);
    chk("end_valid", obs_valid, 0);
    chk("end_ready", obs_req_ready, 1);
    sb_q.delete();
  endtask

  task automatic err_req(input int r0, input int c0);
    sel4      = 1'b1;
    row       = 10'(r0);
    col       = 10'(c0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("err_pulse", obs_err, 1);
    chk("err_no_valid", obs_valid, 0);
    chk("err_busy", obs_req_ready, 0);
    step();
    chk("err_clear", obs_err, 0);
    chk("err_no_valid2", obs_valid, 0);
    chk("err_ready_back", obs_req_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", obs_valid, 0);
    chk("reset_addr", obs_addr, 0);
    chk("reset_bit", obs_bit, 0);
    chk("reset_nidx", obs_nidx, 0);
    chk("reset_last", obs_last, 0);
    chk("reset_err", obs_err, 0);
    chk("reset_req_ready", obs_req_ready, 1);
    rstn = 1'b1;
    step();

    run_burst(10, 40, 0, 15, 0, 15, 15);
    run_burst(0, 0, 0, 15, 0, 15, 15);
    run_burst(511, 511, 0, 15, 0, 15, 15);
    run_burst(5, 31, 0, 15, 0, 15, 15);
    run_burst(10, 40, 0, 2, 3, 5, 15);
    run_burst(10, 40, 1, 15, 0, 15, 15);
    run_burst(0, 511, 1, 15, 0, 15, 15);
    err_req(512, 0);
    err_req(0, 512);
    for (int k = 0; k < 6; k++) begin
      run_burst(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), k % 2, 15, 0, 15, 15);
    end

    run_burst(10, 40, 0, 15, 0, 15, 3);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("no_reissue_valid", obs_valid, 0);
    chk("post_rst_ready", obs_req_ready, 1);
    run_burst(1, 1, 0, 15, 0, 15, 15);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
